// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer slice.
package reorder_buffer_pkg;
  localparam int unsigned NUM_ROB_ENTS = 64;
  localparam int unsigned DISP_WIDTH   = 2;
  localparam int unsigned RETIRE_WIDTH = 4;
  localparam int unsigned NUM_FUS      = 4;
  localparam int unsigned IDXW         = $clog2(NUM_ROB_ENTS);
  localparam int unsigned SLOTW        = $clog2(RETIRE_WIDTH);
  localparam int unsigned RCNTW        = SLOTW + 1;
  localparam int unsigned DCNTW        = $clog2(DISP_WIDTH) + 1;
  localparam int unsigned PC_W         = 32;
  localparam int unsigned REG_W        = 5;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [REG_W-1:0] dst_reg;
    logic             exception;
    logic             br_mispred;
  } rob_entry_t;

  typedef enum logic {ROB_RUN, ROB_FLUSH} rob_state_e;

  typedef logic [IDXW:0] rob_ptr_t;
endpackage

// File: rtl/reorder_buffer_retire_sel.sv
// Head-window scan: picks the in-order run of done entries, stopping after the first flagged one.
module rob_retire_sel
  import reorder_buffer_pkg::*;
(
  input  logic [RETIRE_WIDTH-1:0] win_valid,
  input  logic [RETIRE_WIDTH-1:0] win_done,
  input  logic [RETIRE_WIDTH-1:0] win_flag,
  output logic [RETIRE_WIDTH-1:0] ret_mask_c,
  output logic                    flush_req_c,
  output logic [SLOTW-1:0]        flush_slot_c
);
  logic blocked;

  always_comb begin
    ret_mask_c   = '0;
    flush_req_c  = 1'b0;
    flush_slot_c = '0;
    blocked      = 1'b0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (!blocked && win_valid[k] && win_done[k]) begin
        ret_mask_c[k] = 1'b1;
        if (win_flag[k]) begin
          flush_req_c  = 1'b1;
          flush_slot_c = SLOTW'(k);
          blocked      = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with wide dispatch, multi-port completion and flush on flagged retire.
// Optional ROB_PERF_CNT_EN adds saturating retired/flush counters.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DISP_WIDTH-1:0]                 disp_valid,
  input  rob_entry_t [DISP_WIDTH-1:0]           disp_entry,
  output logic                                  disp_ready,
  output logic [DISP_WIDTH-1:0][IDXW-1:0]       disp_rob_index,
  input  logic [NUM_FUS-1:0]                    cmpl_valid,
  input  logic [NUM_FUS-1:0][IDXW-1:0]          cmpl_rob_index,
  input  logic [NUM_FUS-1:0]                    cmpl_exception,
  input  logic [NUM_FUS-1:0]                    cmpl_br_mispred,
  output logic [RETIRE_WIDTH-1:0]               ret_valid,
  output logic [RETIRE_WIDTH-1:0][REG_W-1:0]    ret_dst_reg,
  output logic [RETIRE_WIDTH-1:0][PC_W-1:0]     ret_pc,
  output logic                                  flush,
  output logic [PC_W-1:0]                       flush_pc,
  output logic                                  rob_empty,
  output logic                                  rob_full
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                           perf_retired,
  output logic [31:0]                           perf_flushes
`endif
);
  rob_state_e state, state_nxt;
  rob_ptr_t   head, tail, head_nxt, tail_nxt, count, free_cnt;

  logic [NUM_ROB_ENTS-1:0] valid_q, done_q, flag_q;
  logic [PC_W-1:0]         pc_mem  [NUM_ROB_ENTS];
  logic [REG_W-1:0]        dst_mem [NUM_ROB_ENTS];

  logic [RETIRE_WIDTH-1:0][IDXW-1:0] win_idx;
  logic [RETIRE_WIDTH-1:0]           win_valid, win_done, win_flag, ret_mask;
  logic                              flush_req;
  logic [SLOTW-1:0]                  flush_slot;
  logic [DISP_WIDTH-1:0]             disp_fire;
  logic [RCNTW-1:0]                  ret_cnt;
  logic [DCNTW-1:0]                  disp_cnt;
  logic                              unused_disp_flags;

  assign unused_disp_flags = ^{disp_entry[0].exception, disp_entry[0].br_mispred,
                               disp_entry[DISP_WIDTH-1].exception, disp_entry[DISP_WIDTH-1].br_mispred};

  assign count      = tail - head;
  assign free_cnt   = rob_ptr_t'(NUM_ROB_ENTS) - count;
  assign rob_empty  = (head == tail);
  assign rob_full   = (count == rob_ptr_t'(NUM_ROB_ENTS));
  assign disp_ready = (state == ROB_RUN) && (free_cnt >= rob_ptr_t'(DISP_WIDTH));
  assign disp_fire  = disp_ready ? disp_valid : '0;

  // Head window and dispatch slot indices, wrapping modulo the entry count.
  always_comb begin
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      win_idx[k]   = head[IDXW-1:0] + IDXW'(k);
      win_valid[k] = valid_q[win_idx[k]] && (state == ROB_RUN);
      win_done[k]  = done_q[win_idx[k]];
      win_flag[k]  = flag_q[win_idx[k]];
    end
    for (int i = 0; i < DISP_WIDTH; i++) begin
      disp_rob_index[i] = tail[IDXW-1:0] + IDXW'(i);
    end
  end

  rob_retire_sel u_sel (
    .win_valid    (win_valid),
    .win_done     (win_done),
    .win_flag     (win_flag),
    .ret_mask_c   (ret_mask),
    .flush_req_c  (flush_req),
    .flush_slot_c (flush_slot)
  );

  // Next-state, pointer advance; a flush pulls tail back onto the new head.
  always_comb begin
    state_nxt = state;
    ret_cnt   = '0;
    disp_cnt  = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) ret_cnt = ret_cnt + RCNTW'(ret_mask[k]);
    for (int i = 0; i < DISP_WIDTH; i++) disp_cnt = disp_cnt + DCNTW'(disp_fire[i]);
    case (state)
      ROB_RUN:   if (flush_req) state_nxt = ROB_FLUSH;
      ROB_FLUSH: state_nxt = ROB_RUN;
      default:   state_nxt = ROB_RUN;
    endcase
    head_nxt = head + rob_ptr_t'(ret_cnt);
    tail_nxt = flush_req ? head_nxt : tail + rob_ptr_t'(disp_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ROB_RUN;
      head      <= '0;
      tail      <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      flag_q    <= '0;
      ret_valid <= '0;
      flush     <= 1'b0;
      flush_pc  <= '0;
    end else begin
      state     <= state_nxt;
      head      <= head_nxt;
      tail      <= tail_nxt;
      ret_valid <= ret_mask;
      flush     <= flush_req;
      if (flush_req) flush_pc <= pc_mem[win_idx[flush_slot]];
      if (state == ROB_RUN) begin
        for (int f = 0; f < NUM_FUS; f++) begin
          if (cmpl_valid[f] && valid_q[cmpl_rob_index[f]]) begin
            done_q[cmpl_rob_index[f]] <= 1'b1;
            flag_q[cmpl_rob_index[f]] <= flag_q[cmpl_rob_index[f]] |
                                         cmpl_exception[f] | cmpl_br_mispred[f];
          end
        end
      end
      for (int i = 0; i < DISP_WIDTH; i++) begin
        if (disp_fire[i]) begin
          valid_q[disp_rob_index[i]] <= 1'b1;
          done_q[disp_rob_index[i]]  <= 1'b0;
          flag_q[disp_rob_index[i]]  <= 1'b0;
        end
      end
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        if (ret_mask[k]) valid_q[win_idx[k]] <= 1'b0;
      end
      if (flush_req) valid_q <= '0;
    end
  end

  // Payload storage and retire datapath carry no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      ret_pc[k]      <= pc_mem[win_idx[k]];
      ret_dst_reg[k] <= dst_mem[win_idx[k]];
    end
    for (int i = 0; i < DISP_WIDTH; i++) begin
      if (disp_fire[i]) begin
        pc_mem[disp_rob_index[i]]  <= disp_entry[i].pc;
        dst_mem[disp_rob_index[i]] <= disp_entry[i].dst_reg;
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [RCNTW-1:0] ret_vld_cnt;
  logic [32:0]      ret_sum;

  always_comb begin
    ret_vld_cnt = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) ret_vld_cnt = ret_vld_cnt + RCNTW'(ret_valid[k]);
    ret_sum = {1'b0, perf_retired} + 33'(ret_vld_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired <= '0;
      perf_flushes <= '0;
    end else begin
      perf_retired <= ret_sum[32] ? '1 : ret_sum[31:0];
      if (flush && (perf_flushes != '1)) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: ordering, full/wrap, flush, stray completion, reset.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DISP_WIDTH-1:0]               disp_valid = '0;
  rob_entry_t [DISP_WIDTH-1:0]         disp_entry = '0;
  logic                                disp_ready;
  logic [DISP_WIDTH-1:0][IDXW-1:0]     disp_rob_index;
  logic [NUM_FUS-1:0]                  cmpl_valid = '0;
  logic [NUM_FUS-1:0][IDXW-1:0]        cmpl_rob_index = '0;
  logic [NUM_FUS-1:0]                  cmpl_exception = '0;
  logic [NUM_FUS-1:0]                  cmpl_br_mispred = '0;
  logic [RETIRE_WIDTH-1:0]             ret_valid;
  logic [RETIRE_WIDTH-1:0][REG_W-1:0]  ret_dst_reg;
  logic [RETIRE_WIDTH-1:0][PC_W-1:0]   ret_pc;
  logic                                flush;
  logic [PC_W-1:0]                     flush_pc;
  logic                                rob_empty, rob_full;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired, perf_flushes;
`endif

  int checks = 0;
  int failures = 0;
  int hd = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_entry(disp_entry),
    .disp_ready(disp_ready), .disp_rob_index(disp_rob_index),
    .cmpl_valid(cmpl_valid), .cmpl_rob_index(cmpl_rob_index),
    .cmpl_exception(cmpl_exception), .cmpl_br_mispred(cmpl_br_mispred),
    .ret_valid(ret_valid), .ret_dst_reg(ret_dst_reg), .ret_pc(ret_pc),
    .flush(flush), .flush_pc(flush_pc), .rob_empty(rob_empty), .rob_full(rob_full)
`ifdef ROB_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = '0;
    cmpl_valid = '0;
    cmpl_exception = '0;
    cmpl_br_mispred = '0;
  endtask

  task automatic disp2(input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [4:0] d0, input logic [4:0] d1, input logic junk);
    disp_valid = 2'b11;
    disp_entry[0].pc = pc0; disp_entry[0].dst_reg = d0;
    disp_entry[0].exception = junk; disp_entry[0].br_mispred = junk;
    disp_entry[1].pc = pc1; disp_entry[1].dst_reg = d1;
    disp_entry[1].exception = junk; disp_entry[1].br_mispred = junk;
  endtask

  task automatic cmpl(input int f, input int idx, input logic exc, input logic mis);
    cmpl_valid[f] = 1'b1;
    cmpl_rob_index[f] = IDXW'(idx % 64);
    cmpl_exception[f] = exc;
    cmpl_br_mispred[f] = mis;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    checks += 6;
    if (rob_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", rob_empty); end
    if (rob_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", rob_full); end
    if (disp_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", disp_ready); end
    if (ret_valid !== 4'b0000) begin failures++; $display("FAIL reset_ret got=%b exp=0000", ret_valid); end
    if (flush !== 1'b0 || flush_pc !== 32'h0) begin failures++; $display("FAIL reset_flush got=%b/%h exp=0/0", flush, flush_pc); end
    if (disp_rob_index[0] !== 6'd0 || disp_rob_index[1] !== 6'd1) begin
      failures++; $display("FAIL reset_index got=%0d,%0d exp=0,1", disp_rob_index[0], disp_rob_index[1]); end
    rst = 1'b0;
    hd = 0;
  endtask

  task automatic test_basic();
    disp2(32'h100, 32'h104, 5'd1, 5'd2, 1'b0); tick(); idle();
    checks += 2;
    if (rob_empty !== 1'b0) begin failures++; $display("FAIL basic_nonempty got=%b exp=0", rob_empty); end
    if (disp_rob_index[0] !== 6'd2) begin failures++; $display("FAIL basic_tail got=%0d exp=2", disp_rob_index[0]); end
    cmpl(0, 1, 1'b0, 1'b0); tick(); idle();
    tick(); tick();
    checks++;
    if (ret_valid !== 4'b0000) begin failures++; $display("FAIL basic_wait got=%b exp=0000", ret_valid); end
    cmpl(0, 0, 1'b0, 1'b0); tick(); idle();
    checks++;
    if (ret_valid !== 4'b0000) begin failures++; $display("FAIL basic_latency got=%b exp=0000", ret_valid); end
    tick();
    checks += 4;
    if (ret_valid !== 4'b0011) begin failures++; $display("FAIL basic_ret got=%b exp=0011", ret_valid); end
    if (ret_pc[0] !== 32'h100 || ret_pc[1] !== 32'h104) begin
      failures++; $display("FAIL basic_pc got=%h,%h exp=100,104", ret_pc[0], ret_pc[1]); end
    if (ret_dst_reg[0] !== 5'd1 || ret_dst_reg[1] !== 5'd2) begin
      failures++; $display("FAIL basic_dst got=%0d,%0d exp=1,2", ret_dst_reg[0], ret_dst_reg[1]); end
    if (rob_empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", rob_empty); end
    tick();
    checks++;
    if (ret_valid !== 4'b0000) begin failures++; $display("FAIL basic_ret_clear got=%b exp=0000", ret_valid); end
    hd = 2;
  endtask

  task automatic test_unalloc();
    cmpl(0, 10, 1'b1, 1'b1); tick(); idle(); tick();
    checks++;
    if (rob_empty !== 1'b1 || ret_valid !== 4'b0000 || flush !== 1'b0) begin
      failures++; $display("FAIL unalloc_nochange got=%b/%b/%b exp=1/0000/0", rob_empty, ret_valid, flush); end
    for (int c = 0; c < 5; c++) begin
      disp2(32'h300 + 32'(8*c), 32'h304 + 32'(8*c), 5'(2*c), 5'(2*c+1), 1'b1); tick();
    end
    idle();
    checks++;
    if (disp_rob_index[0] !== 6'd12) begin failures++; $display("FAIL unalloc_tail got=%0d exp=12", disp_rob_index[0]); end
    for (int f = 0; f < 4; f++) cmpl(f, 2 + f, 1'b0, 1'b0);
    tick();
    for (int f = 0; f < 4; f++) cmpl(f, 6 + f, 1'b0, 1'b0);
    tick(); idle();
    checks += 2;
    if (ret_valid !== 4'b1111) begin failures++; $display("FAIL unalloc_ret1 got=%b exp=1111", ret_valid); end
    if (ret_pc[0] !== 32'h300 || ret_pc[3] !== 32'h30C) begin
      failures++; $display("FAIL unalloc_pc1 got=%h,%h exp=300,30c", ret_pc[0], ret_pc[3]); end
    tick();
    checks += 2;
    if (ret_valid !== 4'b1111 || ret_pc[0] !== 32'h310 || ret_pc[3] !== 32'h31C) begin
      failures++; $display("FAIL unalloc_ret2 got=%b %h,%h exp=1111 310,31c", ret_valid, ret_pc[0], ret_pc[3]); end
    if (flush !== 1'b0) begin failures++; $display("FAIL unalloc_dispflag got=%b exp=0", flush); end
    tick(); tick();
    checks++;
    if (ret_valid !== 4'b0000 || rob_empty !== 1'b0 || flush !== 1'b0) begin
      failures++; $display("FAIL unalloc_notdone got=%b/%b/%b exp=0000/0/0", ret_valid, rob_empty, flush); end
    cmpl(0, 10, 1'b0, 1'b0); cmpl(1, 11, 1'b0, 1'b0); tick(); idle(); tick();
    checks += 2;
    if (ret_valid !== 4'b0011 || ret_pc[0] !== 32'h320 || ret_pc[1] !== 32'h324) begin
      failures++; $display("FAIL unalloc_ret3 got=%b %h,%h exp=0011 320,324", ret_valid, ret_pc[0], ret_pc[1]); end
    if (flush !== 1'b0 || rob_empty !== 1'b1) begin
      failures++; $display("FAIL unalloc_end got=%b/%b exp=0/1", flush, rob_empty); end
    hd = 12;
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_q[$];
    int cq[$];
    int tl = hd;
    int n = 0;
    int cyc = 0;
    logic [31:0] e;
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (disp_ready !== 1'b1) begin failures++; $display("FAIL fill_ready c=%0d got=%b exp=1", c, disp_ready); end
      disp2(32'h1000 + 32'(4*n), 32'h1004 + 32'(4*n), 5'(n), 5'(n+1), 1'b0);
      exp_q.push_back(32'h1000 + 32'(4*n)); exp_q.push_back(32'h1004 + 32'(4*n));
      cq.push_back(tl); cq.push_back(tl + 1);
      tl += 2; n += 2;
      tick();
    end
    idle();
    checks += 2;
    if (rob_full !== 1'b1 || disp_ready !== 1'b0) begin
      failures++; $display("FAIL full_flag got=%b/%b exp=1/0", rob_full, disp_ready); end
    if (disp_rob_index[0] !== 6'(hd)) begin failures++; $display("FAIL full_tail got=%0d exp=%0d", disp_rob_index[0], hd); end
    disp2(32'hDEAD, 32'hBEEF, 5'd0, 5'd0, 1'b0); tick(); idle();
    checks++;
    if (rob_full !== 1'b1) begin failures++; $display("FAIL full_reject got=%b exp=1", rob_full); end
    for (int f = 0; f < 4; f++) cmpl(f, cq.pop_front(), 1'b0, 1'b0);
    tick(); idle(); tick();
    checks += 2;
    if (ret_valid !== 4'b1111) begin failures++; $display("FAIL full_ret got=%b exp=1111", ret_valid); end
    if (disp_ready !== 1'b1 || rob_full !== 1'b0) begin
      failures++; $display("FAIL full_free got=%b/%b exp=1/0", disp_ready, rob_full); end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (ret_pc[k] !== e) begin failures++; $display("FAIL full_pc slot=%0d got=%h exp=%h", k, ret_pc[k], e); end
    end
    tick();
    while ((n < 256 || exp_q.size() > 0) && cyc < 2000) begin
      for (int k = 0; k < 4; k++) begin
        if (ret_valid[k]) begin
          checks++;
          if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_extra slot=%0d got=%h exp=none", k, ret_pc[k]); end
          else begin
            e = exp_q.pop_front();
            if (ret_pc[k] !== e) begin failures++; $display("FAIL wrap_pc slot=%0d got=%h exp=%h", k, ret_pc[k], e); end
          end
        end
      end
      idle();
      for (int f = 0; f < 4; f++) if (cq.size() > 0) cmpl(f, cq.pop_front(), 1'b0, 1'b0);
      if (disp_ready && n < 256) begin
        disp2(32'h1000 + 32'(4*n), 32'h1004 + 32'(4*n), 5'(n), 5'(n+1), 1'b0);
        exp_q.push_back(32'h1000 + 32'(4*n)); exp_q.push_back(32'h1004 + 32'(4*n));
        cq.push_back(tl); cq.push_back(tl + 1);
        tl += 2; n += 2;
      end
      tick();
      cyc++;
    end
    idle();
    checks += 2;
    if (cyc >= 2000) begin failures++; $display("FAIL wrap_timeout got=%0d left exp=0", exp_q.size()); end
    if (rob_empty !== 1'b1 || disp_rob_index[0] !== 6'(tl % 64)) begin
      failures++; $display("FAIL wrap_end got=%b/%0d exp=1/%0d", rob_empty, disp_rob_index[0], tl % 64); end
    hd = tl % 64;
  endtask

  task automatic test_mispredict();
    disp2(32'h200, 32'h204, 5'd3, 5'd4, 1'b0); tick();
    disp2(32'h208, 32'h20C, 5'd5, 5'd6, 1'b0); tick(); idle();
    cmpl(0, hd, 1'b0, 1'b0); cmpl(1, hd + 1, 1'b0, 1'b1);
    cmpl(2, hd + 2, 1'b0, 1'b0); cmpl(3, hd + 3, 1'b0, 1'b0);
    tick(); idle();
    checks++;
    if (ret_valid !== 4'b0000 || flush !== 1'b0) begin
      failures++; $display("FAIL mis_early got=%b/%b exp=0000/0", ret_valid, flush); end
    tick();
    checks += 4;
    if (ret_valid !== 4'b0011) begin failures++; $display("FAIL mis_ret got=%b exp=0011", ret_valid); end
    if (ret_pc[0] !== 32'h200 || ret_pc[1] !== 32'h204) begin
      failures++; $display("FAIL mis_pc got=%h,%h exp=200,204", ret_pc[0], ret_pc[1]); end
    if (flush !== 1'b1 || flush_pc !== 32'h204) begin
      failures++; $display("FAIL mis_flush got=%b/%h exp=1/204", flush, flush_pc); end
    if (rob_empty !== 1'b1 || disp_ready !== 1'b0) begin
      failures++; $display("FAIL mis_state got=%b/%b exp=1/0", rob_empty, disp_ready); end
    tick();
    checks += 2;
    if (flush !== 1'b0 || ret_valid !== 4'b0000 || disp_ready !== 1'b1) begin
      failures++; $display("FAIL mis_after got=%b/%b/%b exp=0/0000/1", flush, ret_valid, disp_ready); end
    if (rob_empty !== 1'b1 || disp_rob_index[0] !== 6'((hd + 2) % 64)) begin
      failures++; $display("FAIL mis_tail got=%b/%0d exp=1/%0d", rob_empty, disp_rob_index[0], (hd + 2) % 64); end
    hd = (hd + 2) % 64;
  endtask

  task automatic test_flush_dispatch();
    disp2(32'h400, 32'h404, 5'd7, 5'd8, 1'b0); tick(); idle();
    cmpl(0, hd, 1'b1, 1'b0); tick(); idle();
    checks++;
    if (disp_ready !== 1'b1) begin failures++; $display("FAIL fd_ready got=%b exp=1", disp_ready); end
    disp2(32'h500, 32'h504, 5'd9, 5'd10, 1'b0); tick(); idle();
    checks += 2;
    if (flush !== 1'b1 || flush_pc !== 32'h400 || ret_valid !== 4'b0001) begin
      failures++; $display("FAIL fd_flush got=%b/%h/%b exp=1/400/0001", flush, flush_pc, ret_valid); end
    if (rob_empty !== 1'b1 || disp_rob_index[0] !== 6'((hd + 1) % 64)) begin
      failures++; $display("FAIL fd_tail got=%b/%0d exp=1/%0d", rob_empty, disp_rob_index[0], (hd + 1) % 64); end
    tick();
    checks++;
    if (rob_empty !== 1'b1 || flush !== 1'b0) begin
      failures++; $display("FAIL fd_discard got=%b/%b exp=1/0", rob_empty, flush); end
    disp2(32'h600, 32'h604, 5'd11, 5'd12, 1'b0); tick(); idle();
    cmpl(0, hd + 1, 1'b0, 1'b0); cmpl(1, hd + 2, 1'b0, 1'b0); tick(); idle(); tick();
    checks++;
    if (ret_valid !== 4'b0011 || ret_pc[0] !== 32'h600 || ret_pc[1] !== 32'h604) begin
      failures++; $display("FAIL fd_resume got=%b %h,%h exp=0011 600,604", ret_valid, ret_pc[0], ret_pc[1]); end
    hd = (hd + 3) % 64;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 10; c++) begin
      disp2(32'h800 + 32'(8*c), 32'h804 + 32'(8*c), 5'(c), 5'(c), 1'b0); tick();
    end
    idle();
    for (int f = 0; f < 4; f++) cmpl(f, hd + f, 1'b0, 1'b0);
    tick(); idle();
    rst = 1'b1; tick(); rst = 1'b0;
    checks += 3;
    if (rob_empty !== 1'b1 || rob_full !== 1'b0) begin
      failures++; $display("FAIL rstmid_empty got=%b/%b exp=1/0", rob_empty, rob_full); end
    if (ret_valid !== 4'b0000 || flush !== 1'b0) begin
      failures++; $display("FAIL rstmid_ret got=%b/%b exp=0000/0", ret_valid, flush); end
    if (disp_ready !== 1'b1 || disp_rob_index[0] !== 6'd0) begin
      failures++; $display("FAIL rstmid_ptr got=%b/%0d exp=1/0", disp_ready, disp_rob_index[0]); end
`ifdef ROB_PERF_CNT_EN
    checks++;
    if (perf_retired !== 32'd0 || perf_flushes !== 32'd0) begin
      failures++; $display("FAIL rstmid_perf got=%0d/%0d exp=0/0", perf_retired, perf_flushes); end
`endif
    hd = 0;
  endtask

`ifdef ROB_PERF_CNT_EN
  task automatic test_perf();
    disp2(32'h700, 32'h704, 5'd1, 5'd2, 1'b0); tick(); idle();
    cmpl(0, 0, 1'b0, 1'b0); cmpl(1, 1, 1'b1, 1'b0); tick(); idle();
    tick(); tick(); tick();
    checks++;
    if (perf_retired !== 32'd2 || perf_flushes !== 32'd1) begin
      failures++; $display("FAIL perf_count got=%0d/%0d exp=2/1", perf_retired, perf_flushes); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_unalloc();
    test_full_wrap();
    test_mispredict();
    test_flush_dispatch();
    test_reset_mid();
`ifdef ROB_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
